// File: rtl/fifo_serializer_pkg.sv
// Shared types and line-level constants for the FIFO drain serializer.
package fifo_serializer_pkg;

    // Frame sequencing states; START through STOP are the on-line portion of a frame.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        CAPTURE = 3'd2,
        START   = 3'd3,
        DATA    = 3'd4,
        PARITY  = 3'd5,
        STOP    = 3'd6
    } serializer_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_counter.sv
// Divide-by-BAUD_DIVIDE counter; tick_c marks the last cycle of each bit period,
// pre_tick_c the cycle before it.
module baud_counter #(
    parameter int unsigned BAUD_DIVIDE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick_c,
    output logic pre_tick_c
);

    localparam int unsigned CNT_W = (BAUD_DIVIDE > 1) ? $clog2(BAUD_DIVIDE) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BAUD_DIVIDE - 1);
    localparam logic [CNT_W-1:0] PRE_LAST_COUNT = CNT_W'(BAUD_DIVIDE - 2);

    logic [CNT_W-1:0] count;

    // Free-running bit-period counter, held at zero while clear is asserted.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick_c     = (count == LAST_COUNT);
    assign pre_tick_c = (count == PRE_LAST_COUNT);

endmodule

// File: rtl/fifo_serializer.sv
// Pops words from the FIFO read port and shifts each one out as an
// asynchronous serial frame: start, SIZE data bits LSB first, optional even
// parity, stop.
module fifo_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int unsigned SIZE          = 8,
    parameter int unsigned BAUD_DIVIDE   = 4,
    parameter int unsigned PARITY_ENABLE = 0
) (
    input  logic            read_clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            empty_flag,
    input  logic [SIZE-1:0] data_in,
    output logic            read_request,
    output logic            serial_out,
    output logic            busy,
    output logic            frame_done
);

    localparam int unsigned BIT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SIZE - 1);

    serializer_state_t state;
    logic [SIZE-1:0]   shift_reg;
    logic              parity_bit;
    logic [BIT_W-1:0]  bit_count;

    logic start_ok_c;
    logic baud_clear_c;
    logic baud_tick_c;
    logic baud_pre_tick_c;

    // A new frame may begin only when permitted and the FIFO has data.
    assign start_ok_c = enable && !empty_flag;

    // The baud counter idles at zero outside the on-line states, so every
    // on-line state is entered with a fresh count; transitions between on-line
    // states happen on the wrap, which also returns the count to zero.
    assign baud_clear_c = (state == IDLE) || (state == REQUEST) || (state == CAPTURE);

    baud_counter #(
        .BAUD_DIVIDE (BAUD_DIVIDE)
    ) u_baud_counter (
        .clk        (read_clock),
        .reset      (reset),
        .clear      (baud_clear_c),
        .tick_c     (baud_tick_c),
        .pre_tick_c (baud_pre_tick_c)
    );

    // Frame sequencer with registered outputs; each output reflects the state being entered.
    always_ff @(posedge read_clock) begin
        if (reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            parity_bit   <= 1'b0;
            bit_count    <= '0;
            read_request <= 1'b0;
            serial_out   <= LINE_IDLE;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            read_request <= 1'b0;
            frame_done   <= 1'b0;

            unique case (state)
                IDLE: begin
                    serial_out <= LINE_IDLE;
                    if (start_ok_c) begin
                        state        <= REQUEST;
                        read_request <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                REQUEST: begin
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    shift_reg  <= data_in;
                    parity_bit <= ^data_in;
                    bit_count  <= '0;
                    state      <= START;
                    serial_out <= START_LEVEL;
                end

                START: begin
                    if (baud_tick_c) begin
                        state      <= DATA;
                        serial_out <= shift_reg[0];
                        shift_reg  <= shift_reg >> 1;
                    end
                end

                DATA: begin
                    if (baud_tick_c) begin
                        if (bit_count == LAST_BIT) begin
                            bit_count <= '0;
                            if (PARITY_ENABLE != 0) begin
                                state      <= PARITY;
                                serial_out <= parity_bit;
                            end else begin
                                state      <= STOP;
                                serial_out <= LINE_IDLE;
                            end
                        end else begin
                            bit_count  <= bit_count + BIT_W'(1);
                            serial_out <= shift_reg[0];
                            shift_reg  <= shift_reg >> 1;
                        end
                    end
                end

                PARITY: begin
                    if (baud_tick_c) begin
                        state      <= STOP;
                        serial_out <= LINE_IDLE;
                    end
                end

                STOP: begin
                    // Raised one cycle early so the registered pulse lands on the final stop cycle.
                    frame_done <= baud_pre_tick_c;
                    if (baud_tick_c) begin
                        if (start_ok_c) begin
                            state        <= REQUEST;
                            read_request <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    serial_out <= LINE_IDLE;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
